// File: rtl/ms_batch_accumulator_pkg.sv
// Shared types for the batch accumulator: section encoding and the
// reference saturating add at the default sample width.
package ms_batch_accumulator_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        sec_recv = 2'd0,
        sec_calc = 2'd1,
        sec_send = 2'd2
    } Sections;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] sum;
        logic                         ovf;
    } sat_result_t;

    // Reference form of the clamp at the default width, shared with
    // property checks that compose this stage with the producer.
    function automatic sat_result_t sat_add(
        input logic signed [DATA_W_DEF-1:0] a,
        input logic signed [DATA_W_DEF-1:0] b
    );
        logic signed [DATA_W_DEF:0] wide;
        sat_result_t                res;
        wide    = {a[DATA_W_DEF-1], a} + {b[DATA_W_DEF-1], b};
        res.ovf = wide[DATA_W_DEF] ^ wide[DATA_W_DEF-1];
        if (!res.ovf)
            res.sum = wide[DATA_W_DEF-1:0];
        else if (wide[DATA_W_DEF])
            res.sum = {1'b1, {(DATA_W_DEF-1){1'b0}}};
        else
            res.sum = {1'b0, {(DATA_W_DEF-1){1'b1}}};
        return res;
    endfunction

endpackage

// File: rtl/ms_batch_accumulator_sat_adder.sv
// Combinational signed saturating adder; the sum is formed one bit wider
// so overflow shows up as disagreement between the top two bits.
module sat_adder #(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_sum,
    output logic                     o_ovf
);

    logic signed [DATA_W:0] w_wide;

    assign w_wide = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};

    // Pass the sum through, or clamp toward the sign of the true result.
    always_comb begin
        o_ovf = w_wide[DATA_W] ^ w_wide[DATA_W-1];
        o_sum = w_wide[DATA_W-1:0];
        if (o_ovf) begin
            if (w_wide[DATA_W])
                o_sum = {1'b1, {(DATA_W-1){1'b0}}};
            else
                o_sum = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/ms_batch_accumulator.sv
// Batch accumulator: takes BATCH_LEN signed samples over valid/ready,
// adds them with saturation and offers the sum on a valid/ready port.
//
// section  | meaning
// ---------+-----------------------------------------------------------
// sec_recv | in_ready high, waiting for the next sample
// sec_calc | one cycle: fold the held sample into the running sum
// sec_send | out_valid high, sum held until downstream takes it
module ms_batch_accumulator
    import ms_batch_accumulator_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BATCH_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic                     err_sat
);

    localparam logic [CNT_W-1:0] LP_BATCH = CNT_W'(BATCH_LEN);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    Sections                  r_section;
    Sections                  w_section_nxt;
    logic signed [DATA_W-1:0] r_acc;
    logic signed [DATA_W-1:0] r_val;
    logic [CNT_W-1:0]         r_sample_cnt;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_err_sat;
    logic signed [DATA_W-1:0] w_sum;
    logic                     w_ovf;
    logic                     w_batch_done;

    sat_adder #(
        .DATA_W (DATA_W)
    ) u_sat_adder (
        .i_a   (r_acc),
        .i_b   (r_val),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    assign w_batch_done = (r_sample_cnt == LP_BATCH);

    // Section sequencing and handshake outputs decoded from the section.
    // in_ready is held low while rst is asserted so upstream never sees
    // a ready that the flops cannot honour.
    always_comb begin
        w_section_nxt = r_section;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (r_section)
            sec_recv: begin
                in_ready = ~rst;
                if (in_valid)
                    w_section_nxt = sec_calc;
            end
            sec_calc: begin
                w_section_nxt = w_batch_done ? sec_send : sec_recv;
            end
            sec_send: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_section_nxt = sec_recv;
            end
            default: w_section_nxt = sec_recv;
        endcase
    end

    // All datapath state; a reset anywhere drops the batch in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_section    <= sec_recv;
            r_acc        <= '0;
            r_val        <= '0;
            r_sample_cnt <= '0;
            r_out_data   <= '0;
            r_err_sat    <= 1'b0;
        end else begin
            r_section <= w_section_nxt;
            case (r_section)
                sec_recv: begin
                    if (in_valid) begin
                        r_val        <= in_data;
                        r_sample_cnt <= r_sample_cnt + LP_ONE;
                    end
                end
                sec_calc: begin
                    r_acc <= w_sum;
                    if (w_ovf)
                        r_err_sat <= 1'b1;
                    if (w_batch_done)
                        r_out_data <= w_sum;
                end
                sec_send: begin
                    if (out_ready) begin
                        r_acc        <= '0;
                        r_sample_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data   = r_out_data;
    assign sample_cnt = r_sample_cnt;
    assign err_sat    = r_err_sat;

endmodule

// File: tb/tb_ms_batch_accumulator.sv
// Scoreboard bench: the driver folds each accepted sample into a
// reference sum and queues it per batch; monitors pop on out handshakes.
module tb_ms_batch_accumulator;

    localparam longint MAXV = 64'sh7FFF_FFFF;
    localparam longint MINV = -64'sh8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic signed [31:0] in_data, out_data, in_data1, out_data1;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic               in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0]         sample_cnt, sample_cnt1;
    logic               err_sat, err_sat1;

    ms_batch_accumulator #(.DATA_W(32), .BATCH_LEN(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sample_cnt(sample_cnt), .err_sat(err_sat)
    );

    ms_batch_accumulator #(.DATA_W(32), .BATCH_LEN(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sample_cnt(sample_cnt1), .err_sat(err_sat1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // reference model for the BATCH_LEN=4 instance
    longint             m_acc = 0;
    int                 m_cnt = 0;
    logic signed [31:0] q[$];
    logic signed [31:0] q1[$];
    int                 last_acc_cyc = 0;
    int                 last_acc_cyc1 = 0;
    int                 exp_vlen = 1;

    function automatic longint clamp(input longint s);
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
    endfunction

    task automatic drive(input logic signed [31:0] v, input int gap);
        int budget = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("accept_timeout", budget >= 50, 0);
        last_acc_cyc = cyc;
        m_cnt++;
        m_acc = clamp(m_acc + longint'(v));
        if (m_cnt == 4) begin
            q.push_back(32'(m_acc));
            m_acc = 0;
            m_cnt = 0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("rdy_calc", in_ready, 0);
    endtask

    task automatic drain();
        int budget = 0;
        while ((q.size() != 0 || q1.size() != 0) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_timeout", budget >= 100, 0);
        @(negedge clk);
    endtask

    task automatic drive1(input logic signed [31:0] v);
        int budget = 0;
        in_data1  = v;
        in_valid1 = 1'b1;
        while (!in_ready1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("accept1_timeout", budget >= 50, 0);
        last_acc_cyc1 = cyc;
        q1.push_back(v);
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    // Output monitor for the BATCH_LEN=4 instance
    int                 vcnt = 0;
    bit                 prev_v = 1'b0;
    logic signed [31:0] prev_data;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            vcnt   = 0;
            prev_v = 1'b0;
        end else begin
            chk("rdy_vs_valid", in_ready && out_valid, 0);
            if (out_valid) begin
                if (!prev_v)
                    chk("latency", cyc - last_acc_cyc, 2);
                else
                    chk("hold", out_data, prev_data);
                vcnt++;
                if (out_ready) begin
                    if (q.size() == 0)
                        chk("unexpected_out", 1, 0);
                    else
                        chk("sum", out_data, q.pop_front());
                    chk("valid_len", vcnt, exp_vlen);
                    vcnt = 0;
                end
            end
            prev_v    = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    // Output monitor for the BATCH_LEN=1 instance
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid1 && out_ready1) begin
            chk("latency1", cyc - last_acc_cyc1, 2);
            if (q1.size() == 0)
                chk("unexpected_out1", 1, 0);
            else
                chk("sum1", out_data1, q1.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data = 0; in_valid = 0; out_ready = 1;
        in_data1 = 0; in_valid1 = 0; out_ready1 = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err_sat, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // 1,2,3,4 back to back
        drive(1, 0); drive(2, 0); drive(3, 0); drive(4, 0);
        drain();
        chk("cnt_after_batch", sample_cnt, 0);
        chk("err_clean", err_sat, 0);

        // gapped samples summing to zero
        drive(-5, 3); drive(7, 3); drive(-2, 3); drive(0, 3);
        drain();

        // downstream stall for 5 cycles on a sum of 8
        out_ready = 1'b0;
        exp_vlen  = 6;
        drive(2, 0); drive(2, 0); drive(2, 0); drive(2, 0);
        begin
            int budget = 0;
            while (!out_valid && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            chk("stall_wait_timeout", budget >= 20, 0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 8);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();
        exp_vlen = 1;
        chk("back_to_recv", in_ready, 1);

        // positive saturation, then sticky flag across a clean batch
        drive(32'sh7FFF_FFFF, 0); drive(1, 0); drive(1, 0); drive(1, 0);
        drain();
        chk("err_set", err_sat, 1);
        drive(1, 0); drive(1, 0); drive(1, 0); drive(1, 0);
        drain();
        chk("err_sticky", err_sat, 1);

        // negative saturation
        drive(32'sh8000_0000, 0); drive(-1, 0); drive(0, 0); drive(0, 0);
        drain();

        // reset mid-batch discards the partial sum and clears err_sat
        drive(10, 0); drive(20, 0);
        rst = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        chk("midrst_cnt", sample_cnt, 0);
        chk("midrst_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_err", err_sat, 0);
        chk("midrst_cnt_after", sample_cnt, 0);
        drive(5, 0); drive(6, 0); drive(7, 0); drive(8, 0);
        drain();

        // single-sample batches
        drive1(3);
        drive1(-3);
        drain();
        chk("q_empty", q.size() + q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
